fft_sample_buffer: RTL and testbench
====================================

Name: fft_sample_buffer

Overview:
- Data-memory responder for the 1024-point radix-2 DIT FFT engine.
- Accepts a natural-order real sample stream and stores it in bit-reversed order as complex data (im = 0).
- Starts the engine, serves its butterfly reads combinationally on i_top/i_bot, and captures its y_top/y_bot write-backs.
- After the engine signals Done, streams the N bins out in natural order, then returns Ack so the engine goes back to INIT.

Parameters:
N, 1024, transform length (power of two)
M, 10, log2(N); address width
DW, 32, signed width of each real/imag word

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
In_valid  input  1  input sample valid
In_ready  output  1  buffer accepts a sample this cycle
In_sample  input  DW  signed real input sample
Start  output  1  one-cycle start pulse to the FFT engine
Fft_busy  input  1  engine in its processing state; write-back enable
Fft_done  input  1  engine Done flag
Ack  output  1  one-cycle acknowledge to the engine
i_top  input  M  engine top read/write index
i_bot  input  M  engine bottom read/write index
x_top_re, x_top_im, x_bot_re, x_bot_im  output  DW each  data at i_top / i_bot
y_top_re, y_top_im, y_bot_re, y_bot_im  input  DW each  butterfly results to store
Out_valid  output  1  output bin valid
Out_ready  input  1  downstream accepts the bin
Out_index  output  M  bin number (natural order)
Out_re, Out_im  output  DW each  bin value

Behaviour:
- Storage: N entries of {re, im}, each DW bits.
- Combinational read port 1: x_top = mem[i_top], x_bot = mem[i_bot].
- Combinational read port 2: Out_re/Out_im = mem[cnt].
- Reset is asynchronous on Reset_n low:
  - state = LOAD, cnt = 0.
  - Start = 0, Ack = 0, Out_valid = 0, Out_index = 0.
  - Memory is not cleared; contents are unspecified until the next full load.
- States: LOAD, START, RUN, UNLOAD, ACK. One counter cnt (M bits).
- LOAD:
  - In_ready = 1. In_ready is 0 in every other state.
  - On In_valid && In_ready: mem[bitrev(cnt)] <= {In_sample, 0}; cnt++.
  - bitrev reverses all M bits (example, M = 10: 9 -> 576).
  - When sample N-1 is accepted: cnt <= 0, go to START.
- START:
  - Lasts exactly 1 cycle with Start = 1, then RUN.
  - Start is 0 in all other states.
- RUN:
  - On each posedge with Fft_busy = 1: mem[i_top] <= y_top, mem[i_bot] <= y_bot.
  - If i_top == i_bot, the bottom write wins.
  - Reads see old data until the edge, so the engine's read-modify-write is single-cycle.
  - Fft_done = 1 (sampled) -> UNLOAD, cnt = 0.
  - If Fft_busy and Fft_done are both high, the write still occurs.
- Outside RUN: Fft_busy and Fft_done are ignored and no engine writes occur.
- UNLOAD:
  - Out_valid = 1, Out_index = cnt.
  - On Out_ready: cnt++.
  - While Out_valid && !Out_ready, Out_index/Out_re/Out_im hold stable.
  - When bin N-1 is accepted -> ACK.
- ACK:
  - Lasts exactly 1 cycle with Ack = 1, then LOAD with cnt = 0.
  - Ack is 0 in all other states.
  - The engine holds Done until it sees Ack.
- Arithmetic: none. Values are stored verbatim; no scaling or saturation.
- Reset mid-operation (any state): immediately return to reset values. A pending engine run is abandoned; the engine must also be reset.

Test Plan:
1. Bit-reversed load: feed In_sample = n for n = 0..1023 with Fft_busy = 0.
   - i_top = 1 -> x_top_re = 512, x_top_im = 0.
   - i_bot = 576 -> x_bot_re = 9.
   - i_top = 0 -> x_top_re = 0.
2. Start timing: In_ready drops the cycle after the 1024th accept; Start is high for exactly that one cycle, then 0.
3. Write-back in RUN: Fft_busy = 1 for one edge with i_top = 0, i_bot = 1, y_top = (100, -5), y_bot = (7, 8).
   - Next cycle: x_top = (100, -5), x_bot = (7, 8).
   - Repeat with Fft_busy = 0 -> no change.
4. End-to-end with the FFT engine: impulse input (sample 0 = 1000, others 0).
   - Out stream gives Out_index 0..1023, each bin Out_re = 1000, Out_im = 0.
   - Ack pulses once, then In_ready = 1.
5. Backpressure: hold Out_ready = 0 for 3 cycles at Out_index = 5.
   - Index and data stay stable.
   - No Ack until index 1023 is accepted; Ack follows 1 cycle later.
6. Reset mid-RUN:
   - Drop Reset_n -> Start/Ack/Out_valid = 0 and In_ready = 1 asynchronously.
   - A new 1024-sample load then behaves as in scenario 1.

Source files
------------

// File: rtl/fft_sample_buffer.sv
// Sample memory for the 1024-point radix-2 DIT FFT engine: bit-reversed load,
// in-place butterfly write-back and natural-order unload, sequenced by one FSM.
module fft_sample_buffer #(
   parameter int N  = 1024,
   parameter int M  = 10,
   parameter int DW = 32
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 In_valid,
   output logic                 In_ready,
   input  logic signed [DW-1:0] In_sample,
   output logic                 Start,
   input  logic                 Fft_busy,
   input  logic                 Fft_done,
   output logic                 Ack,
   input  logic [M-1:0]         i_top,
   input  logic [M-1:0]         i_bot,
   output logic signed [DW-1:0] x_top_re,
   output logic signed [DW-1:0] x_top_im,
   output logic signed [DW-1:0] x_bot_re,
   output logic signed [DW-1:0] x_bot_im,
   input  logic signed [DW-1:0] y_top_re,
   input  logic signed [DW-1:0] y_top_im,
   input  logic signed [DW-1:0] y_bot_re,
   input  logic signed [DW-1:0] y_bot_im,
   output logic                 Out_valid,
   input  logic                 Out_ready,
   output logic [M-1:0]         Out_index,
   output logic signed [DW-1:0] Out_re,
   output logic signed [DW-1:0] Out_im
);

   typedef enum logic [2:0] {LOAD, START, RUN, UNLOAD, ACK} state_t;

   localparam logic [M-1:0] LastIdx = M'(N - 1);

   state_t state_q, state_d;
   logic [M-1:0] cnt_q, cnt_d;
   logic [M-1:0] cntRev;
   logic loadAccept;
   logic runWrite;

   logic signed [DW-1:0] memRe_q [N];
   logic signed [DW-1:0] memIm_q [N];

   always_comb begin
      cntRev = '0;
      for (int k = 0; k < M; k++) begin
         cntRev[k] = cnt_q[M-1-k];
      end
   end

   assign In_ready   = (state_q == LOAD);
   assign Start      = (state_q == START);
   assign Ack        = (state_q == ACK);
   assign Out_valid  = (state_q == UNLOAD);
   assign Out_index  = Out_valid ? cnt_q : '0;
   assign loadAccept = In_ready && In_valid;
   assign runWrite   = (state_q == RUN) && Fft_busy;

   assign x_top_re = memRe_q[i_top];
   assign x_top_im = memIm_q[i_top];
   assign x_bot_re = memRe_q[i_bot];
   assign x_bot_im = memIm_q[i_bot];
   assign Out_re   = memRe_q[cnt_q];
   assign Out_im   = memIm_q[cnt_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         LOAD: begin
            if (In_valid) begin
               if (cnt_q == LastIdx) begin
                  cnt_d   = '0;
                  state_d = START;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         START: state_d = RUN;
         RUN: begin
            if (Fft_done) begin
               cnt_d   = '0;
               state_d = UNLOAD;
            end
         end
         UNLOAD: begin
            if (Out_ready) begin
               if (cnt_q == LastIdx) begin
                  cnt_d   = '0;
                  state_d = ACK;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ACK: begin
            cnt_d   = '0;
            state_d = LOAD;
         end
         default: begin
            cnt_d   = '0;
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory has no reset; the bottom write is issued last so it wins when i_top == i_bot.
   always_ff @(posedge Clk) begin
      if (loadAccept) begin
         memRe_q[cntRev] <= In_sample;
         memIm_q[cntRev] <= '0;
      end
      if (runWrite) begin
         memRe_q[i_top] <= y_top_re;
         memIm_q[i_top] <= y_top_im;
         memRe_q[i_bot] <= y_bot_re;
         memIm_q[i_bot] <= y_bot_im;
      end
   end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Self-checking bench for fft_sample_buffer; the bench plays the FFT engine and
// keeps a reference copy of the memory built from natural-order/bit-reverse arithmetic.
module tb_fft_sample_buffer;

   localparam int N  = 1024;
   localparam int M  = 10;
   localparam int DW = 32;

   logic                 Clk = 1'b0;
   logic                 Reset_n;
   logic                 In_valid;
   logic                 In_ready;
   logic signed [DW-1:0] In_sample;
   logic                 Start;
   logic                 Fft_busy;
   logic                 Fft_done;
   logic                 Ack;
   logic [M-1:0]         i_top;
   logic [M-1:0]         i_bot;
   logic signed [DW-1:0] x_top_re, x_top_im, x_bot_re, x_bot_im;
   logic signed [DW-1:0] y_top_re, y_top_im, y_bot_re, y_bot_im;
   logic                 Out_valid;
   logic                 Out_ready;
   logic [M-1:0]         Out_index;
   logic signed [DW-1:0] Out_re, Out_im;

   int checks = 0;
   int errors = 0;
   logic signed [DW-1:0] refRe [N];
   logic signed [DW-1:0] refIm [N];

   fft_sample_buffer #(.N(N), .M(M), .DW(DW)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .In_valid(In_valid), .In_ready(In_ready), .In_sample(In_sample),
      .Start(Start), .Fft_busy(Fft_busy), .Fft_done(Fft_done), .Ack(Ack),
      .i_top(i_top), .i_bot(i_bot),
      .x_top_re(x_top_re), .x_top_im(x_top_im), .x_bot_re(x_bot_re), .x_bot_im(x_bot_im),
      .y_top_re(y_top_re), .y_top_im(y_top_im), .y_bot_re(y_bot_re), .y_bot_im(y_bot_im),
      .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_index(Out_index),
      .Out_re(Out_re), .Out_im(Out_im)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired observed timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int bitRev(input int n);
      int r, v;
      r = 0;
      v = n;
      for (int k = 0; k < M; k++) begin
         r = r * 2 + v % 2;
         v = v / 2;
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkRead(input int top, input int bot);
      i_top = M'(top);
      i_bot = M'(bot);
      #1;
      checkOutput("x_top_re", x_top_re, refRe[top]);
      checkOutput("x_top_im", x_top_im, refIm[top]);
      checkOutput("x_bot_re", x_bot_re, refRe[bot]);
      checkOutput("x_bot_im", x_bot_im, refIm[bot]);
   endtask

   // kind 0 = ramp n, kind 1 = impulse of 1000, kind 2 = random samples while the
   // engine lines toggle randomly (they must be ignored outside RUN).
   task automatic applyStimulus(input int kind);
      logic signed [DW-1:0] v;
      for (int n = 0; n < N; n++) begin
         while ($urandom_range(3) == 0) begin
            In_valid = 1'b0;
            if (kind == 2) begin
               Fft_busy = 1'($urandom);
               Fft_done = 1'($urandom);
               i_top    = M'($urandom);
               i_bot    = M'($urandom);
               y_top_re = DW'($urandom);
               y_bot_re = DW'($urandom);
            end
            tick();
         end
         case (kind)
            0:       v = DW'(n);
            1:       v = (n == 0) ? DW'(1000) : '0;
            default: v = DW'($urandom);
         endcase
         if (n == N - 1) checkOutput("in_ready_last", In_ready, 1);
         In_valid  = 1'b1;
         In_sample = v;
         refRe[bitRev(n)] = v;
         refIm[bitRev(n)] = '0;
         tick();
      end
      In_valid = 1'b0;
      Fft_busy = 1'b0;
      Fft_done = 1'b0;
      checkOutput("start_pulse", Start, 1);
      checkOutput("in_ready_drop", In_ready, 0);
      tick();
      checkOutput("start_low", Start, 0);
      checkOutput("in_ready_run", In_ready, 0);
   endtask

   task automatic engineWrite(input int top, input int bot,
                              input logic signed [DW-1:0] tr, input logic signed [DW-1:0] ti,
                              input logic signed [DW-1:0] br, input logic signed [DW-1:0] bi,
                              input bit busy, input bit done);
      i_top = M'(top);
      i_bot = M'(bot);
      y_top_re = tr; y_top_im = ti; y_bot_re = br; y_bot_im = bi;
      Fft_busy = busy;
      Fft_done = done;
      tick();
      if (busy) begin
         refRe[top] = tr; refIm[top] = ti;
         refRe[bot] = br; refIm[bot] = bi;
      end
      Fft_busy = 1'b0;
      Fft_done = 1'b0;
   endtask

   task automatic unloadAndCheck(input bit stallAt5);
      int idx, cyc;
      bit stalled;
      idx = 0;
      cyc = 0;
      stalled = 1'b0;
      while (idx < N && cyc < 20 * N) begin
         if (stallAt5 && idx == 5 && !stalled) begin
            stalled = 1'b1;
            Out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               checkOutput("stall_index", Out_index, 5);
               checkOutput("stall_re", Out_re, refRe[5]);
               checkOutput("stall_im", Out_im, refIm[5]);
               checkOutput("stall_valid", Out_valid, 1);
               tick();
               cyc++;
            end
         end
         Out_ready = ($urandom_range(3) != 0);
         #1;
         checkOutput("out_valid", Out_valid, 1);
         checkOutput("ack_early", Ack, 0);
         if (Out_ready) begin
            checkOutput("out_index", Out_index, idx);
            checkOutput("out_re", Out_re, refRe[idx]);
            checkOutput("out_im", Out_im, refIm[idx]);
            idx++;
         end
         tick();
         cyc++;
      end
      Out_ready = 1'b0;
      if (idx < N) checkOutput("unload_timeout", idx, N);
      #1;
      checkOutput("ack_pulse", Ack, 1);
      checkOutput("out_valid_drop", Out_valid, 0);
      tick();
      checkOutput("ack_low", Ack, 0);
      checkOutput("in_ready_after_ack", In_ready, 1);
   endtask

   initial begin
      Reset_n = 1'b0;
      In_valid = 1'b0; In_sample = '0;
      Fft_busy = 1'b0; Fft_done = 1'b0;
      i_top = '0; i_bot = '0;
      y_top_re = '0; y_top_im = '0; y_bot_re = '0; y_bot_im = '0;
      Out_ready = 1'b0;
      #1;
      checkOutput("rst_in_ready", In_ready, 1);
      checkOutput("rst_start", Start, 0);
      checkOutput("rst_ack", Ack, 0);
      checkOutput("rst_out_valid", Out_valid, 0);
      checkOutput("rst_out_index", Out_index, 0);
      #1;
      Reset_n = 1'b1;
      tick();

      $display("[TB] ramp load in bit-reversed order");
      applyStimulus(0);
      i_top = M'(1); i_bot = M'(576);
      #1;
      checkOutput("bitrev_1", x_top_re, 512);
      checkOutput("bitrev_1_im", x_top_im, 0);
      checkOutput("bitrev_576", x_bot_re, 9);
      i_top = '0;
      #1;
      checkOutput("bitrev_0", x_top_re, 0);
      for (int k = 0; k < 16; k++) checkRead($urandom_range(N - 1), $urandom_range(N - 1));

      $display("[TB] write-back in RUN");
      engineWrite(0, 1, 100, -5, 7, 8, 1'b1, 1'b0);
      i_top = '0; i_bot = M'(1);
      #1;
      checkOutput("wb_top_re", x_top_re, 100);
      checkOutput("wb_top_im", x_top_im, -5);
      checkOutput("wb_bot_re", x_bot_re, 7);
      checkOutput("wb_bot_im", x_bot_im, 8);
      engineWrite(0, 1, 11, 22, 33, 44, 1'b0, 1'b0);
      checkRead(0, 1);
      engineWrite(3, 3, 55, 66, 77, 88, 1'b1, 1'b0);
      checkOutput("same_idx_bottom_wins", refRe[3], 77);
      checkRead(3, 3);
      for (int k = 0; k < 40; k++) begin
         engineWrite($urandom_range(N - 1), $urandom_range(N - 1), DW'($urandom), DW'($urandom),
                     DW'($urandom), DW'($urandom), 1'($urandom), 1'b0);
         checkRead($urandom_range(N - 1), $urandom_range(N - 1));
      end
      engineWrite(10, 20, -1, -2, -3, -4, 1'b1, 1'b1);
      checkRead(10, 20);

      $display("[TB] unload with backpressure");
      unloadAndCheck(1'b1);

      $display("[TB] impulse through a twiddle-free engine (exact for an impulse)");
      applyStimulus(1);
      for (int s = 0; s < M; s++) begin
         int h;
         h = 1 << s;
         for (int g = 0; g < N; g += 2 * h) begin
            for (int j = 0; j < h; j++) begin
               i_top = M'(g + j);
               i_bot = M'(g + j + h);
               #1;
               y_top_re = x_top_re + x_bot_re;
               y_top_im = x_top_im + x_bot_im;
               y_bot_re = x_top_re - x_bot_re;
               y_bot_im = x_top_im - x_bot_im;
               Fft_busy = 1'b1;
               tick();
            end
         end
      end
      Fft_busy = 1'b0;
      Fft_done = 1'b1;
      tick();
      Fft_done = 1'b0;
      for (int k = 0; k < N; k++) begin
         refRe[k] = DW'(1000);
         refIm[k] = '0;
      end
      unloadAndCheck(1'b0);

      $display("[TB] reset in the middle of RUN");
      applyStimulus(2);
      engineWrite(5, 6, 1, 2, 3, 4, 1'b1, 1'b0);
      #2;
      Reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_in_ready", In_ready, 1);
      checkOutput("mid_rst_start", Start, 0);
      checkOutput("mid_rst_ack", Ack, 0);
      checkOutput("mid_rst_out_valid", Out_valid, 0);
      checkOutput("mid_rst_out_index", Out_index, 0);
      #2;
      Reset_n = 1'b1;
      tick();
      applyStimulus(0);
      i_top = M'(1); i_bot = M'(576);
      #1;
      checkOutput("reload_bitrev_1", x_top_re, 512);
      checkOutput("reload_bitrev_576", x_bot_re, 9);
      for (int k = 0; k < 8; k++) checkRead($urandom_range(N - 1), $urandom_range(N - 1));
      engineWrite(0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      unloadAndCheck(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
